// File: rtl/calc_key_entry.sv
// Calculator operand-entry sequencer: keypad events -> BCD operands/op select,
// ALU evaluation timing, result hold for display and result chaining.
module calc_key_entry #(
  parameter int CALC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] alu_res,
  input  logic        alu_sign,
  input  logic        alu_ovf,
  output logic [15:0] reg1,
  output logic [15:0] reg2,
  output logic        regop,
  output logic        busy,
  output logic        res_valid,
  output logic [15:0] disp_bcd,
  output logic        disp_sign,
  output logic        disp_err
);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} state_t;

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_EQ  = 4'hC;
  localparam logic [3:0] K_CLR = 4'hD;
  localparam logic [3:0] WAIT_LOAD = 4'(CALC_CYCLES);

  state_t      state, state_nx;
  logic [15:0] reg1_nx, reg2_nx;
  logic        regop_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [3:0]  wcnt, wcnt_nx;
  logic [15:0] held_res, held_res_nx;
  logic        held_sign, held_sign_nx;
  logic        held_ovf, held_ovf_nx;
  logic        res_valid_nx;

  logic is_digit, is_op, is_eq, is_clr;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && ((key_code == K_ADD) || (key_code == K_SUB));
  assign is_eq    = key_valid && (key_code == K_EQ);
  assign is_clr   = key_valid && (key_code == K_CLR);

  // Leading zeros into an all-zero operand don't consume digit capacity.
  function automatic logic digit_ok(input logic [15:0] r, input logic [2:0] c,
                                    input logic [3:0] d);
    return (c < 3'd4) && !((d == 4'd0) && (r == 16'd0));
  endfunction

  always_comb begin
    state_nx     = state;
    reg1_nx      = reg1;
    reg2_nx      = reg2;
    regop_nx     = regop;
    cnt_nx       = cnt;
    wcnt_nx      = wcnt;
    held_res_nx  = held_res;
    held_sign_nx = held_sign;
    held_ovf_nx  = held_ovf;
    res_valid_nx = 1'b0;
    if (is_clr) begin
      state_nx     = ENTER_A;
      reg1_nx      = 16'd0;
      reg2_nx      = 16'd0;
      regop_nx     = 1'b1;
      cnt_nx       = 3'd0;
      wcnt_nx      = 4'd0;
      held_res_nx  = 16'd0;
      held_sign_nx = 1'b0;
      held_ovf_nx  = 1'b0;
    end else begin
      unique case (state)
        ENTER_A: begin
          if (is_digit && digit_ok(reg1, cnt, key_code)) begin
            reg1_nx = {reg1[11:0], key_code};
            cnt_nx  = cnt + 3'd1;
          end else if (is_op) begin
            regop_nx = (key_code == K_ADD);
            reg2_nx  = 16'd0;
            cnt_nx   = 3'd0;
            state_nx = ENTER_B;
          end
        end
        ENTER_B: begin
          if (is_digit && digit_ok(reg2, cnt, key_code)) begin
            reg2_nx = {reg2[11:0], key_code};
            cnt_nx  = cnt + 3'd1;
          end else if (is_op) begin
            regop_nx = (key_code == K_ADD);
          end else if (is_eq) begin
            wcnt_nx  = WAIT_LOAD;
            state_nx = CALC;
          end
        end
        CALC: begin
          // Last busy cycle: ALU output has settled on the frozen operands.
          if (wcnt <= 4'd1) begin
            held_res_nx  = alu_res;
            held_sign_nx = alu_sign;
            held_ovf_nx  = alu_ovf;
            res_valid_nx = 1'b1;
            wcnt_nx      = 4'd0;
            state_nx     = SHOW;
          end else begin
            wcnt_nx = wcnt - 4'd1;
          end
        end
        SHOW: begin
          if (is_digit) begin
            reg1_nx  = {12'd0, key_code};
            cnt_nx   = (key_code != 4'd0) ? 3'd1 : 3'd0;
            reg2_nx  = 16'd0;
            state_nx = ENTER_A;
          end else if (is_op && !held_sign && !held_ovf) begin
            reg1_nx  = held_res;
            regop_nx = (key_code == K_ADD);
            reg2_nx  = 16'd0;
            cnt_nx   = 3'd0;
            state_nx = ENTER_B;
          end
        end
        default: state_nx = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ENTER_A;
      reg1      <= 16'd0;
      reg2      <= 16'd0;
      regop     <= 1'b1;
      cnt       <= 3'd0;
      wcnt      <= 4'd0;
      held_res  <= 16'd0;
      held_sign <= 1'b0;
      held_ovf  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      reg1      <= reg1_nx;
      reg2      <= reg2_nx;
      regop     <= regop_nx;
      cnt       <= cnt_nx;
      wcnt      <= wcnt_nx;
      held_res  <= held_res_nx;
      held_sign <= held_sign_nx;
      held_ovf  <= held_ovf_nx;
      res_valid <= res_valid_nx;
    end
  end

  assign busy = (state == CALC);

  always_comb begin
    disp_bcd  = reg1;
    disp_sign = 1'b0;
    disp_err  = 1'b0;
    unique case (state)
      ENTER_A: disp_bcd = reg1;
      ENTER_B, CALC: disp_bcd = reg2;
      SHOW: begin
        disp_bcd  = held_res;
        disp_sign = held_sign;
        disp_err  = held_ovf;
      end
      default: disp_bcd = reg1;
    endcase
  end

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed + randomized bench for calc_key_entry against an integer-level
// model of the calculator entry rules, with a registered BCD ALU alongside.
module tb_calc_key_entry;
  localparam int C = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [15:0] alu_res = 16'd0;
  logic        alu_sign = 1'b0;
  logic        alu_ovf = 1'b0;
  logic [15:0] reg1, reg2, disp_bcd;
  logic        regop, busy, res_valid, disp_sign, disp_err;

  int checks = 0;
  int errors = 0;

  calc_key_entry #(.CALC_CYCLES(C)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .alu_res(alu_res), .alu_sign(alu_sign), .alu_ovf(alu_ovf),
    .reg1(reg1), .reg2(reg2), .regop(regop), .busy(busy), .res_valid(res_valid),
    .disp_bcd(disp_bcd), .disp_sign(disp_sign), .disp_err(disp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] int2bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int bcd2int(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // Calculator arithmetic: 4-digit magnitude, sign on subtract, overflow on add.
  function automatic void alu_fn(input int a, input int b, input logic add,
                                 output int r, output logic s, output logic o);
    if (add) begin
      r = (a + b) % 10000; s = 1'b0; o = (a + b) > 9999;
    end else begin
      r = (a >= b) ? a - b : b - a; s = (a < b); o = 1'b0;
    end
  endfunction

  int   ar;
  logic as_c, ao_c;
  always_comb alu_fn(bcd2int(reg1), bcd2int(reg2), regop, ar, as_c, ao_c);
  always @(posedge clk) begin
    alu_res  <= int2bcd(ar);
    alu_sign <= as_c;
    alu_ovf  <= ao_c;
  end

  // Reference model: modes 0=A entry, 1=B entry, 2=calculating, 3=showing.
  int   m_mode, m_a, m_b, m_n, m_res, m_cyc, m_eq;
  logic m_add, m_sign, m_ovf, m_rv;

  task automatic model_reset();
    m_mode = 0; m_a = 0; m_b = 0; m_n = 0; m_res = 0;
    m_add = 1'b1; m_sign = 1'b0; m_ovf = 1'b0; m_rv = 1'b0;
  endtask

  task automatic enter(inout int v, inout int n, input int d);
    if (n < 4 && !(d == 0 && v == 0)) begin
      v = v * 10 + d;
      n = n + 1;
    end
  endtask

  task automatic model_step(input logic v, input int k);
    m_cyc++;
    m_rv = 1'b0;
    if (v && k == 13) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: if (v && k <= 9) enter(m_a, m_n, k);
         else if (v && (k == 10 || k == 11)) begin
           m_add = (k == 10); m_b = 0; m_n = 0; m_mode = 1;
         end
      1: if (v && k <= 9) enter(m_b, m_n, k);
         else if (v && (k == 10 || k == 11)) m_add = (k == 10);
         else if (v && k == 12) begin m_mode = 2; m_eq = m_cyc; end
      2: if (m_cyc - m_eq == C) begin
           alu_fn(m_a, m_b, m_add, m_res, m_sign, m_ovf);
           m_rv = 1'b1; m_mode = 3;
         end
      default:
        if (v && k <= 9) begin
          m_a = k; m_n = (k != 0) ? 1 : 0; m_b = 0; m_mode = 0;
        end else if (v && (k == 10 || k == 11) && !m_sign && !m_ovf) begin
          m_a = m_res; m_add = (k == 10); m_b = 0; m_n = 0; m_mode = 1;
        end
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".reg1"}, reg1, int2bcd(m_a));
    chk({tag, ".reg2"}, reg2, int2bcd(m_b));
    chk({tag, ".regop"}, {15'd0, regop}, {15'd0, m_add});
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, m_mode == 2});
    chk({tag, ".res_valid"}, {15'd0, res_valid}, {15'd0, m_rv});
    chk({tag, ".disp_bcd"}, disp_bcd,
        m_mode == 0 ? int2bcd(m_a) : (m_mode == 3 ? int2bcd(m_res) : int2bcd(m_b)));
    chk({tag, ".disp_sign"}, {15'd0, disp_sign}, {15'd0, m_mode == 3 && m_sign});
    chk({tag, ".disp_err"}, {15'd0, disp_err}, {15'd0, m_mode == 3 && m_ovf});
  endtask

  // One clock edge: drive away from the edge, step the model, sample after.
  task automatic cyc(input string tag, input logic rst, input logic v, input int k);
    @(negedge clk);
    reset = rst; key_valid = v; key_code = 4'(k);
    @(posedge clk);
    if (rst) model_reset(); else model_step(v, k);
    #1 check_all(tag);
  endtask

  task automatic key(input string tag, input int k);
    cyc(tag, 1'b0, 1'b1, k);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 0);
  endtask

  initial begin
    m_cyc = 0; m_eq = 0;
    model_reset();
    cyc("rst", 1'b1, 1'b0, 0);
    chk("rst.regop_lit", {15'd0, regop}, 16'd1);
    chk("rst.disp_lit", disp_bcd, 16'h0000);

    // 12 + 34
    key("t1", 1); key("t1", 2); key("t1", 10); key("t1", 3); key("t1", 4);
    key("t1.eq", 12);
    chk("t1.busy0", {15'd0, busy}, 16'd1);
    idle("t1.w", 1);
    chk("t1.busy1", {15'd0, busy}, 16'd1);
    idle("t1.w", 1);
    chk("t1.rv", {15'd0, res_valid}, 16'd1);
    chk("t1.reg1_lit", reg1, 16'h0012);
    chk("t1.reg2_lit", reg2, 16'h0034);
    chk("t1.disp_lit", disp_bcd, 16'h0046);
    idle("t1.show", 1);

    // Chaining a positive result
    key("chain", 11);
    chk("chain.reg1_lit", reg1, 16'h0046);
    chk("chain.regop_lit", {15'd0, regop}, 16'd0);

    // Leading zeros and capacity
    key("clr", 13);
    key("lz", 0); key("lz", 0); key("lz", 7);
    chk("lz.reg1_lit", reg1, 16'h0007);
    key("cap", 1); key("cap", 2); key("cap", 3); key("cap", 4);
    chk("cap.reg1_lit", reg1, 16'h7123);
    key("clr", 13);
    for (int d = 1; d <= 5; d++) key("cap5", d);
    chk("cap5.reg1_lit", reg1, 16'h1234);

    // '=' in A ignored; op replacement in B
    key("clr", 13);
    key("op", 5); key("op.eqA", 12);
    chk("op.eqA_busy", {15'd0, busy}, 16'd0);
    key("op", 11); key("op", 10); key("op", 9); key("op.eq", 12);
    chk("op.regop_lit", {15'd0, regop}, 16'd1);
    idle("op.w", C + 1);

    // Negative result: chaining refused, sign held
    key("clr", 13);
    key("neg", 5); key("neg", 11); key("neg", 9); key("neg", 12);
    idle("neg.w", C + 1);
    key("neg.chain", 11);
    chk("neg.sign_lit", {15'd0, disp_sign}, 16'd1);
    chk("neg.disp_lit", disp_bcd, 16'h0004);

    // Overflow: chaining refused, error held
    key("clr", 13);
    for (int i = 0; i < 4; i++) key("ovf", 9);
    key("ovf", 10); key("ovf", 1); key("ovf", 12);
    idle("ovf.w", C + 1);
    key("ovf.chain", 10);
    chk("ovf.err_lit", {15'd0, disp_err}, 16'd1);

    // Clear on the second CALC cycle aborts
    key("clr", 13);
    key("cab", 1); key("cab", 10); key("cab", 2); key("cab", 12);
    idle("cab", 1);
    key("cab.clr", 13);
    chk("cab.busy_lit", {15'd0, busy}, 16'd0);
    chk("cab.rv_lit", {15'd0, res_valid}, 16'd0);
    idle("cab.after", 3);

    // Keys during CALC ignored
    key("kc", 1); key("kc", 10); key("kc", 2); key("kc", 12);
    key("kc.d", 3); key("kc.op", 11);
    chk("kc.reg2_lit", reg2, 16'h0002);
    idle("kc.w", 2);

    // Reset mid-CALC: no result pulse afterwards
    key("rc", 10); key("rc", 4); key("rc", 12);
    cyc("rc.rst", 1'b1, 1'b0, 0);
    idle("rc.after", 3);

    // Randomized key streams
    for (int i = 0; i < 2000; i++) begin
      int r, k;
      r = $urandom_range(0, 99);
      if (r < 55) k = $urandom_range(0, 9);
      else if (r < 65) k = 10;
      else if (r < 75) k = 11;
      else if (r < 88) k = 12;
      else if (r < 93) k = 13;
      else k = $urandom_range(14, 15);
      cyc("rnd", ($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0), k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_key_entry.md
# calc_key_entry

Operand-entry sequencer for the calculator. It turns one-cycle keypad events into the two 4-digit packed-BCD operand registers and the operation select that the calculator ALU consumes, and it times the ALU evaluation. It then holds the ALU result for display and supports chaining that result into the next calculation. It sits between the keypad scanner/debouncer and the ALU/display path.

## Interface
Parameters:
- CALC_CYCLES, default 2: cycles to wait after '=' before sampling the ALU result. Legal range 2..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle key event strobe.
- key_code  in  4  key: 0x0–0x9 digit, 0xA '+', 0xB '-', 0xC '=', 0xD clear; 0xE/0xF ignored.
- alu_res  in  16  ALU result, packed BCD.
- alu_sign  in  1  ALU negative-result flag.
- alu_ovf  in  1  ALU overflow flag.
- reg1  out  16  operand A, packed BCD, digit 3 in [15:12].
- reg2  out  16  operand B, packed BCD.
- regop  out  1  1 = add, 0 = subtract.
- busy  out  1  high while waiting on the ALU.
- res_valid  out  1  one-cycle pulse when the result is captured.
- disp_bcd  out  16  value to display.
- disp_sign  out  1  minus sign for display.
- disp_err  out  1  overflow indication for display.

## Operation
- States: ENTER_A, ENTER_B, CALC, SHOW. A 3-bit digit counter tracks digits entered in the current operand.
- Reset values: state ENTER_A; reg1 = reg2 = 0; regop = 1; digit count 0; busy = 0; res_valid = 0; held result, sign and err = 0.
- Digit entry in ENTER_A (into reg1) and ENTER_B (into reg2):
  - A digit shifts in from the right: reg = {reg[11:0], d}, and the count increments.
  - At count 4, further digits are ignored with no change.
  - A 0 while the operand is 0 leaves the operand and count unchanged, so leading zeros do not use capacity.
- ENTER_A:
  - '+' or '-' sets regop to 1 or 0, clears reg2 and the count, and goes to ENTER_B.
  - '=' is ignored.
- ENTER_B:
  - '+' or '-' replaces regop and stays in ENTER_B. reg2 is not cleared.
  - '=' goes to CALC and loads the wait counter with CALC_CYCLES.
- CALC:
  - reg1, reg2 and regop are frozen; busy = 1.
  - Every key except clear is ignored.
  - When the wait counter expires, alu_res, alu_sign and alu_ovf are captured into the held result and the block goes to SHOW.
- SHOW:
  - A digit starts a new calculation: reg1 = digit (or 0 for key 0), count = 1 (or 0 for key 0), reg2 = 0, state ENTER_A.
  - '+' or '-' chains: if the held sign = 0 and held ovf = 0, then reg1 = held result, regop is set, reg2 = 0, count = 0, and the block goes to ENTER_B. Otherwise the key is ignored.
  - '=' is ignored.
- Clear (0xD) in any state, including CALC, returns the block to the reset values on the next edge.
- Display outputs:
  - disp_bcd = reg1 in ENTER_A, reg2 in ENTER_B, reg2 in CALC, held result in SHOW.
  - disp_sign and disp_err are the held sign and ovf in SHOW, and 0 otherwise.
- Codes 0xE/0xF and any key_valid = 0 cycle cause no change.

## Timing
- A key is accepted at the rising edge where key_valid = 1. The register and state updates are visible in the following cycle. At most one key is processed per cycle.
- busy is high for exactly CALC_CYCLES cycles, starting the cycle after the '=' edge.
- The result capture occurs on the edge that ends the last busy cycle. res_valid is high for the single following cycle, coincident with the first SHOW cycle.
- The '=' edge to first SHOW cycle latency is CALC_CYCLES + 1 cycles.
- reg1, reg2 and regop are stable throughout CALC. The ALU registers on every edge, so its output is settled by capture when CALC_CYCLES ≥ 2.
- Synchronous reset and clear take priority over any simultaneous key or counter event. A reset asserted mid-CALC aborts the calculation: no res_valid pulse follows.

## Test plan
- Reset -> all outputs 0 except regop = 1; state ENTER_A; disp_bcd = 0x0000.
- Keys 1,2,'+',3,4,'=' with an ALU model returning 0x0046 -> reg1 = 0x0012, reg2 = 0x0034, regop = 1; busy high for 2 cycles; res_valid pulses 3 cycles after '='; disp_bcd = 0x0046.
- Keys 0,0,7 then 1,2,3,4 -> reg1 = 0x0007 after the first three keys, then 0x7123 with the 4th digit held and the last key ignored. Also 1,2,3,4,5 -> reg1 = 0x1234.
- Keys 5,'-','+',9,'=' -> regop = 1 at CALC entry; '=' pressed in ENTER_A has no effect.
- Chaining:
  - From SHOW with result 0x0046 and sign = 0, key '-' -> reg1 = 0x0046, regop = 0, state ENTER_B.
  - With sign = 1 or ovf = 1, '-' is ignored and disp_err / disp_sign hold.
- Clear pressed on the second CALC cycle -> next cycle busy = 0, reg1 = reg2 = 0, no res_valid. Keys pressed during CALC other than clear leave reg2 unchanged.
